// File: rtl/basic_control_unit.sv
// Hardwired T0..T6 sequencer for the 16-bit accumulator datapath; optional interrupt support via BASIC_CTRL_INTERRUPT_EN.
// Latency: controls are combinational from SC/IR/flags and take effect at the next rising edge.
// Backpressure: none; HLT freezes SC and forces every control to 0 until reset.
module basic_control_unit #(
    parameter logic [2:0] ALU_AND = 3'd0,
    parameter logic [2:0] ALU_ADD = 3'd1,
    parameter logic [2:0] ALU_LDA = 3'd2,
    parameter logic [2:0] ALU_CMA = 3'd3,
    parameter logic [2:0] ALU_CIR = 3'd4,
    parameter logic [2:0] ALU_CIL = 3'd5
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [15:0] IR_out,
    input  logic [15:0] AC_out,
    input  logic        DR_ZERO,
    input  logic        IEN_out,
    input  logic        R_out,
    input  logic        FGI,
    input  logic        FGO,
    output logic        AR_load,
    output logic        PC_load,
    output logic        DR_load,
    output logic        AC_load,
    output logic        IR_load,
    output logic        TR_load,
    output logic        OUTR_load,
    output logic        AR_reset,
    output logic        PC_reset,
    output logic        DR_reset,
    output logic        AC_reset,
    output logic        TR_reset,
    output logic        IEN_reset,
    output logic        R_reset,
    output logic        IEN_set,
    output logic        R_load,
    output logic        AR_inc,
    output logic        PC_inc,
    output logic        DR_inc,
    output logic        AC_inc,
    output logic        M_read,
    output logic        M_write,
    output logic [2:0]  BUS_sel,
    output logic [2:0]  ALU_ops,
    output logic [2:0]  SC,
    output logic        halted
);
    localparam logic [2:0] OP_AND = 3'd0, OP_ADD = 3'd1, OP_LDA = 3'd2, OP_STA = 3'd3;
    localparam logic [2:0] OP_BUN = 3'd4, OP_BSA = 3'd5, OP_ISZ = 3'd6, OP_REG = 3'd7;
    localparam logic [2:0] BUS_AR = 3'd1, BUS_PC = 3'd2, BUS_DR = 3'd3, BUS_AC = 3'd4;
    localparam logic [2:0] BUS_IR = 3'd5, BUS_TR = 3'd6, BUS_M  = 3'd7;

    logic [2:0]  sc_q, sc_d;
    logic        halted_q, halted_d, i_lat_q, i_lat_d;
    logic [2:0]  opcode;
    logic [11:0] b;
    logic        int_cycle, int_detect;
    logic        unused_inputs;

    assign opcode = IR_out[14:12];
    assign b      = IR_out[11:0];
    assign SC     = sc_q;
    assign halted = halted_q;

`ifdef BASIC_CTRL_INTERRUPT_EN
    // R_out only steers T0..T2; an instruction already past T2 completes normally.
    assign int_cycle     = R_out && (sc_q <= 3'd2);
    assign int_detect    = (sc_q > 3'd2) && IEN_out && (FGI || FGO) && !R_out;
    assign unused_inputs = &{1'b0, IR_out[1]};
`else
    assign int_cycle     = 1'b0;
    assign int_detect    = 1'b0;
    assign unused_inputs = &{1'b0, IR_out[1], R_out, IEN_out};
`endif

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            sc_q     <= 3'd0;
            halted_q <= 1'b0;
            i_lat_q  <= 1'b0;
        end else begin
            sc_q     <= sc_d;
            halted_q <= halted_d;
            i_lat_q  <= i_lat_d;
        end
    end

    always_comb begin
        sc_d     = sc_q + 3'd1;
        halted_d = halted_q;
        i_lat_d  = i_lat_q;
        if (halted_q) begin
            sc_d = sc_q;
        end else if (int_cycle) begin
            if (sc_q == 3'd2) sc_d = 3'd0;
        end else begin
            case (sc_q)
                3'd2: i_lat_d = IR_out[15];
                3'd3: if (opcode == OP_REG) begin
                    sc_d = 3'd0;
                    if (!i_lat_q && b[0]) halted_d = 1'b1;
                end
                3'd4: if (opcode == OP_STA || opcode == OP_BUN) sc_d = 3'd0;
                3'd5: if (opcode != OP_ISZ) sc_d = 3'd0;
                3'd6: sc_d = 3'd0;
                default: ;
            endcase
        end
    end

    always_comb begin
        {AR_load, PC_load, DR_load, AC_load, IR_load, TR_load, OUTR_load} = '0;
        {AR_reset, PC_reset, DR_reset, AC_reset, TR_reset, IEN_reset, R_reset} = '0;
        {IEN_set, R_load, AR_inc, PC_inc, DR_inc, AC_inc, M_read, M_write} = '0;
        BUS_sel = 3'd0;
        ALU_ops = 3'd0;
        if (!reset_n) begin
            {AR_reset, PC_reset, DR_reset, AC_reset, TR_reset, IEN_reset, R_reset} = '1;
        end else if (!halted_q) begin
            R_load = int_detect;
            if (int_cycle) begin
                case (sc_q)
                    3'd0: begin AR_reset = 1'b1; BUS_sel = BUS_PC; TR_load = 1'b1; end
                    3'd1: begin BUS_sel = BUS_TR; M_write = 1'b1; PC_reset = 1'b1; end
                    default: begin PC_inc = 1'b1; IEN_reset = 1'b1; R_reset = 1'b1; end
                endcase
            end else begin
                case (sc_q)
                    3'd0: begin BUS_sel = BUS_PC; AR_load = 1'b1; end
                    3'd1: begin BUS_sel = BUS_M; M_read = 1'b1; IR_load = 1'b1; PC_inc = 1'b1; end
                    3'd2: begin BUS_sel = BUS_IR; AR_load = 1'b1; end
                    3'd3: begin
                        if (opcode != OP_REG) begin
                            if (i_lat_q) begin BUS_sel = BUS_M; M_read = 1'b1; AR_load = 1'b1; end
                        end else if (!i_lat_q) begin
                            // Register reference: B bits may combine, giving the union of actions.
                            if (b[11]) AC_reset = 1'b1;
                            if (b[9]) begin ALU_ops = ALU_CMA; AC_load = 1'b1; end
                            if (b[7]) begin ALU_ops = ALU_CIR; AC_load = 1'b1; end
                            if (b[6]) begin ALU_ops = ALU_CIL; AC_load = 1'b1; end
                            if (b[5]) AC_inc = 1'b1;
                            if ((b[4] && !AC_out[15]) || (b[3] && AC_out[15]) ||
                                (b[2] && AC_out == 16'd0)) PC_inc = 1'b1;
                        end else begin
                            if ((b[9] && FGI) || (b[8] && FGO)) PC_inc = 1'b1;
                            if (b[7]) IEN_set = 1'b1;
                            if (b[6]) IEN_reset = 1'b1;
                            if (b[10]) begin BUS_sel = BUS_AC; OUTR_load = 1'b1; end
                        end
                    end
                    3'd4: begin
                        case (opcode)
                            OP_AND, OP_ADD, OP_LDA, OP_ISZ: begin
                                BUS_sel = BUS_M; M_read = 1'b1; DR_load = 1'b1;
                            end
                            OP_STA: begin BUS_sel = BUS_AC; M_write = 1'b1; end
                            OP_BUN: begin BUS_sel = BUS_AR; PC_load = 1'b1; end
                            OP_BSA: begin BUS_sel = BUS_PC; M_write = 1'b1; AR_inc = 1'b1; end
                            default: ;
                        endcase
                    end
                    3'd5: begin
                        case (opcode)
                            OP_AND: begin ALU_ops = ALU_AND; AC_load = 1'b1; end
                            OP_ADD: begin ALU_ops = ALU_ADD; AC_load = 1'b1; end
                            OP_LDA: begin ALU_ops = ALU_LDA; AC_load = 1'b1; end
                            OP_BSA: begin BUS_sel = BUS_AR; PC_load = 1'b1; end
                            OP_ISZ: DR_inc = 1'b1;
                            default: ;
                        endcase
                    end
                    3'd6: begin BUS_sel = BUS_DR; M_write = 1'b1; PC_inc = DR_ZERO; end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_basic_control_unit.sv
// Scoreboard bench for basic_control_unit: per-step expected control vectors are queued and compared at negedge+1.
module tb_basic_control_unit;
    typedef struct packed {
        logic ar_load, pc_load, dr_load, ac_load, ir_load, tr_load, outr_load;
        logic ar_reset, pc_reset, dr_reset, ac_reset, tr_reset, ien_reset, r_reset;
        logic ien_set, r_load, ar_inc, pc_inc, dr_inc, ac_inc, m_read, m_write;
        logic [2:0] bus_sel;
        logic [2:0] alu_ops;
        logic [2:0] sc;
        logic halted;
    } ctrl_t;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [15:0] IR_out, AC_out;
    logic        DR_ZERO, IEN_out, R_out, FGI, FGO;
    logic        AR_load, PC_load, DR_load, AC_load, IR_load, TR_load, OUTR_load;
    logic        AR_reset, PC_reset, DR_reset, AC_reset, TR_reset, IEN_reset, R_reset;
    logic        IEN_set, R_load, AR_inc, PC_inc, DR_inc, AC_inc, M_read, M_write;
    logic [2:0]  BUS_sel, ALU_ops, SC;
    logic        halted;

    int    vectors = 0;
    int    miscompares = 0;
    ctrl_t sb[$];
    ctrl_t obs;

    always #5 clock = ~clock;

    basic_control_unit dut (
        .clock(clock), .reset_n(reset_n), .IR_out(IR_out), .AC_out(AC_out),
        .DR_ZERO(DR_ZERO), .IEN_out(IEN_out), .R_out(R_out), .FGI(FGI), .FGO(FGO),
        .AR_load(AR_load), .PC_load(PC_load), .DR_load(DR_load), .AC_load(AC_load),
        .IR_load(IR_load), .TR_load(TR_load), .OUTR_load(OUTR_load),
        .AR_reset(AR_reset), .PC_reset(PC_reset), .DR_reset(DR_reset), .AC_reset(AC_reset),
        .TR_reset(TR_reset), .IEN_reset(IEN_reset), .R_reset(R_reset),
        .IEN_set(IEN_set), .R_load(R_load), .AR_inc(AR_inc), .PC_inc(PC_inc),
        .DR_inc(DR_inc), .AC_inc(AC_inc), .M_read(M_read), .M_write(M_write),
        .BUS_sel(BUS_sel), .ALU_ops(ALU_ops), .SC(SC), .halted(halted)
    );

    assign obs = {AR_load, PC_load, DR_load, AC_load, IR_load, TR_load, OUTR_load,
                  AR_reset, PC_reset, DR_reset, AC_reset, TR_reset, IEN_reset, R_reset,
                  IEN_set, R_load, AR_inc, PC_inc, DR_inc, AC_inc, M_read, M_write,
                  BUS_sel, ALU_ops, SC, halted};

    // Reference: the fetch steps, or an idle vector carrying SC for later steps.
    function automatic ctrl_t step_exp(int t);
        ctrl_t e;
        e = '0;
        e.sc = 3'(t);
        case (t)
            0: begin e.ar_load = 1'b1; e.bus_sel = 3'd2; end
            1: begin e.bus_sel = 3'd7; e.m_read = 1'b1; e.ir_load = 1'b1; e.pc_inc = 1'b1; end
            2: begin e.ar_load = 1'b1; e.bus_sel = 3'd5; end
            default: ;
        endcase
        return e;
    endfunction

    function automatic ctrl_t reset_exp(logic [2:0] sc, logic h);
        ctrl_t e;
        e = '0;
        {e.ar_reset, e.pc_reset, e.dr_reset, e.ac_reset, e.tr_reset, e.ien_reset, e.r_reset} = '1;
        e.sc = sc;
        e.halted = h;
        return e;
    endfunction

    task automatic sample(output ctrl_t o, output ctrl_t x);
        #1;
        o = obs;
        x = sb.pop_front();
    endtask

    task automatic test_reset();
        ctrl_t o, x;
        reset_n = 1'b0;
        @(negedge clock);
        sb.push_back(reset_exp(3'd0, 1'b0));
        sample(o, x);
        if (o !== x) begin $display("FAIL reset: got %h want %h", o, x); miscompares++; end
        vectors++;
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic test_mem_alu();
        ctrl_t o, x, e;
        logic [15:0] irs [3];
        irs = '{16'h0050, 16'h1050, 16'h2050};
        for (int k = 0; k < 3; k++) begin
            IR_out = irs[k];
            for (int t = 0; t < 6; t++) begin
                e = step_exp(t);
                if (t == 4) begin e.dr_load = 1'b1; e.m_read = 1'b1; e.bus_sel = 3'd7; end
                if (t == 5) begin e.ac_load = 1'b1; e.alu_ops = 3'(k); end
                sb.push_back(e);
                sample(o, x);
                if (o !== x) begin
                    $display("FAIL mem_alu ir=%h T%0d: got %h want %h", irs[k], t, o, x);
                    miscompares++;
                end
                vectors++;
                @(negedge clock);
            end
        end
    endtask

    task automatic test_isz();
        ctrl_t o, x, e;
        IR_out = 16'hE050;
        for (int dz = 1; dz >= 0; dz--) begin
            for (int t = 0; t < 7; t++) begin
                DR_ZERO = (t == 6) ? 1'(dz) : ~1'(dz);
                e = step_exp(t);
                if (t == 3) begin e.bus_sel = 3'd7; e.m_read = 1'b1; e.ar_load = 1'b1; end
                if (t == 4) begin e.bus_sel = 3'd7; e.m_read = 1'b1; e.dr_load = 1'b1; end
                if (t == 5) e.dr_inc = 1'b1;
                if (t == 6) begin e.bus_sel = 3'd3; e.m_write = 1'b1; e.pc_inc = 1'(dz); end
                sb.push_back(e);
                sample(o, x);
                if (o !== x) begin
                    $display("FAIL isz dz=%0d T%0d: got %h want %h", dz, t, o, x);
                    miscompares++;
                end
                vectors++;
                @(negedge clock);
            end
        end
        DR_ZERO = 1'b0;
    endtask

    // Covers both register-reference (I=0) and I/O (I=1) decode at T3.
    task automatic test_reg_io();
        ctrl_t o, x, e;
        logic [15:0] irs [14];
        logic [15:0] acs [14];
        logic [1:0]  flg [14];
        irs = '{16'h7800, 16'h7200, 16'h7080, 16'h7040, 16'h7020, 16'h7010, 16'h7008,
                16'h7004, 16'hF400, 16'hF200, 16'hF100, 16'hF080, 16'hF040, 16'hF800};
        acs = '{16'h1234, 16'h1234, 16'h1234, 16'h1234, 16'h1234, 16'h0001, 16'h8000,
                16'h0005, 16'h1234, 16'h1234, 16'h1234, 16'h1234, 16'h1234, 16'h1234};
        flg = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00,
                2'b00, 2'b00, 2'b10, 2'b10, 2'b00, 2'b00, 2'b11};
        for (int k = 0; k < 14; k++) begin
            IR_out = irs[k];
            AC_out = acs[k];
            {FGI, FGO} = flg[k];
            for (int t = 0; t < 4; t++) begin
                e = step_exp(t);
                if (t == 3) begin
                    case (k)
                        0: e.ac_reset = 1'b1;
                        1: begin e.ac_load = 1'b1; e.alu_ops = 3'd3; end
                        2: begin e.ac_load = 1'b1; e.alu_ops = 3'd4; end
                        3: begin e.ac_load = 1'b1; e.alu_ops = 3'd5; end
                        4: e.ac_inc = 1'b1;
                        5, 6, 9: e.pc_inc = 1'b1;
                        8: begin e.bus_sel = 3'd4; e.outr_load = 1'b1; end
                        11: e.ien_set = 1'b1;
                        12: e.ien_reset = 1'b1;
                        default: ;
                    endcase
                end
                sb.push_back(e);
                sample(o, x);
                if (o !== x) begin
                    $display("FAIL reg_io ir=%h T%0d: got %h want %h", irs[k], t, o, x);
                    miscompares++;
                end
                vectors++;
                @(negedge clock);
            end
        end
        {FGI, FGO} = 2'b00;
        AC_out = 16'h0000;
    endtask

    task automatic test_bsa_reset();
        ctrl_t o, x, e;
        IR_out = 16'h5050;
        for (int run = 0; run < 2; run++) begin
            for (int t = 0; t < 6; t++) begin
                e = step_exp(t);
                if (t == 4) begin e.bus_sel = 3'd2; e.m_write = 1'b1; e.ar_inc = 1'b1; end
                if (t == 5) begin e.bus_sel = 3'd1; e.pc_load = 1'b1; end
                if (t == 5 && run == 1) begin
                    reset_n = 1'b0;
                    e = reset_exp(3'd5, 1'b0);
                end
                sb.push_back(e);
                sample(o, x);
                if (o !== x) begin
                    $display("FAIL bsa run%0d T%0d: got %h want %h", run, t, o, x);
                    miscompares++;
                end
                vectors++;
                @(negedge clock);
            end
        end
        sb.push_back(reset_exp(3'd0, 1'b0));
        sample(o, x);
        if (o !== x) begin $display("FAIL bsa_abort: got %h want %h", o, x); miscompares++; end
        vectors++;
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic test_interrupt();
        ctrl_t o, x, e;
        IR_out  = 16'h7800;
        IEN_out = 1'b1;
        FGI     = 1'b1;
        for (int t = 0; t < 7; t++) begin
            e = step_exp(t < 4 ? t : t - 4);
            if (t == 3) begin
                e.ac_reset = 1'b1;
`ifdef BASIC_CTRL_INTERRUPT_EN
                e.r_load = 1'b1;
`endif
            end
            if (t >= 4) R_out = 1'b1;
`ifdef BASIC_CTRL_INTERRUPT_EN
            if (t >= 4) begin
                e = '0;
                e.sc = 3'(t - 4);
                case (t)
                    4: begin e.ar_reset = 1'b1; e.bus_sel = 3'd2; e.tr_load = 1'b1; end
                    5: begin e.bus_sel = 3'd6; e.m_write = 1'b1; e.pc_reset = 1'b1; end
                    default: begin e.pc_inc = 1'b1; e.ien_reset = 1'b1; e.r_reset = 1'b1; end
                endcase
            end
`endif
            sb.push_back(e);
            sample(o, x);
            if (o !== x) begin
                $display("FAIL interrupt step%0d: got %h want %h", t, o, x);
                miscompares++;
            end
            vectors++;
            @(negedge clock);
        end
        R_out   = 1'b0;
        IEN_out = 1'b0;
        FGI     = 1'b0;
`ifndef BASIC_CTRL_INTERRUPT_EN
        // Interrupt support absent: the CLA fetched above still owes its T3.
        e = step_exp(3);
        e.ac_reset = 1'b1;
        sb.push_back(e);
        sample(o, x);
        if (o !== x) begin $display("FAIL interrupt tail: got %h want %h", o, x); miscompares++; end
        vectors++;
        @(negedge clock);
`endif
    endtask

    task automatic test_halt();
        ctrl_t o, x, e;
        IR_out = 16'h7001;
        for (int t = 0; t < 24; t++) begin
            e = step_exp(t < 4 ? t : 0);
            if (t >= 4) begin e = '0; e.halted = 1'b1; end
            sb.push_back(e);
            sample(o, x);
            if (o !== x) begin $display("FAIL halt step%0d: got %h want %h", t, o, x); miscompares++; end
            vectors++;
            @(negedge clock);
        end
        reset_n = 1'b0;
        for (int t = 0; t < 2; t++) begin
            sb.push_back(reset_exp(3'd0, t == 0));
            sample(o, x);
            if (o !== x) begin $display("FAIL halt_clear%0d: got %h want %h", t, o, x); miscompares++; end
            vectors++;
            @(negedge clock);
        end
        reset_n = 1'b1;
        sb.push_back(step_exp(0));
        sample(o, x);
        if (o !== x) begin $display("FAIL halt_restart: got %h want %h", o, x); miscompares++; end
        vectors++;
    endtask

    initial begin
        reset_n = 1'b0;
        IR_out  = 16'h0000;
        AC_out  = 16'h0000;
        DR_ZERO = 1'b0;
        IEN_out = 1'b0;
        R_out   = 1'b0;
        FGI     = 1'b0;
        FGO     = 1'b0;
        test_reset();
        test_mem_alu();
        test_isz();
        test_reg_io();
        test_bsa_reset();
        test_interrupt();
        test_halt();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/basic_control_unit.md
Name: basic_control_unit

Overview:
- Hardwired sequencer for the 16-bit accumulator datapath (AR/PC/DR/AC/IR/TR/IEN/R, bus mux, ALU, memory).
- Runs a 3-bit sequence counter SC (T0..T6), decodes the instruction held in IR, and drives every datapath load/reset/inc, M_read/M_write, BUS_sel and ALU_ops line.
- Executes the fetch/decode/indirect, memory-reference, register-reference and I/O cycles, plus the interrupt cycle.

Parameters:
- ALU_AND, 3'd0, ALU_ops code for AC AND DR
- ALU_ADD, 3'd1, ALU_ops code for AC + DR
- ALU_LDA, 3'd2, ALU_ops code for pass DR
- ALU_CMA, 3'd3, ALU_ops code for complement AC
- ALU_CIR, 3'd4, ALU_ops code for rotate right through E
- ALU_CIL, 3'd5, ALU_ops code for rotate left through E

Ports:
- clock  in  1  system clock, rising edge
- reset_n  in  1  synchronous, active-low reset
- IR_out  in  16  instruction register: [15]=I, [14:12]=opcode, [11:0]=B bits
- AC_out  in  16  accumulator, used by SPA/SNA/SZA
- DR_ZERO  in  1  DR == 0
- IEN_out  in  1  interrupt enable flop
- R_out  in  1  interrupt-cycle flop
- FGI  in  1  input flag
- FGO  in  1  output flag
- AR_load, PC_load, DR_load, AC_load, IR_load, TR_load, OUTR_load  out  1 each  register loads
- AR_reset, PC_reset, DR_reset, AC_reset, TR_reset, IEN_reset, R_reset  out  1 each  register clears
- IEN_set, R_load  out  1 each  set IEN / set R
- AR_inc, PC_inc, DR_inc, AC_inc  out  1 each  increments
- M_read, M_write  out  1 each  memory strobes
- BUS_sel  out  3  bus source: 0 zero, 1 AR, 2 PC, 3 DR, 4 AC, 5 IR, 6 TR, 7 M
- ALU_ops  out  3  ALU operation
- SC  out  3  current timing step
- halted  out  1  HLT executed

Behaviour:
- State: SC, halted, I_lat. Controls are combinational from SC, R_out, IR_out, I_lat and flags; they take effect at the next rising edge.
- All controls default to 0. BUS_sel and ALU_ops default to 0.
- Reset (reset_n=0 at edge): SC=0, halted=0, I_lat=0. While reset_n=0, the block asserts AR/PC/DR/AC/TR/IEN/R_reset and holds all other controls at 0.
- Memory reads are combinational from AR, so M_read and the destination load occur in the same step.
- Fetch (R=0):
  - T0: BUS=AR source PC (1→…: BUS_sel=2), AR_load.
  - T1: BUS_sel=7, M_read, IR_load, PC_inc.
  - T2: BUS_sel=5, AR_load; I_lat<=IR[15].
- T3, opcode!=7:
  - I_lat=1: BUS_sel=7, M_read, AR_load (indirect).
  - I_lat=0: no action.
- Memory reference, T4 onward (every SC<=0 below also ends the instruction):
  - AND/ADD: T4 DR<=M. T5 ALU_AND/ALU_ADD with AC_load, SC<=0.
  - LDA: T4 DR<=M. T5 ALU_LDA with AC_load, SC<=0.
  - STA: T4 BUS_sel=4, M_write, SC<=0.
  - BUN: T4 BUS_sel=1, PC_load, SC<=0.
  - BSA: T4 BUS_sel=2, M_write, AR_inc. T5 BUS_sel=1, PC_load, SC<=0.
  - ISZ: T4 DR<=M. T5 DR_inc. T6 BUS_sel=3, M_write, PC_inc if DR_ZERO, SC<=0.
- Register reference (opcode 7, I=0), at T3, SC<=0. One-hot on IR[11:0]:
  - CLA: AC_reset.
  - CMA, CIR, CIL: matching ALU code with AC_load.
  - INC: AC_inc.
  - SPA: PC_inc if AC[15]=0.
  - SNA: PC_inc if AC[15]=1.
  - SZA: PC_inc if AC==0.
  - HLT: halted<=1.
  - CLE, CME, SZE: no-op (E not controllable).
  - Multiple B bits set: union of actions; same-register conflicts are undefined.
- I/O (opcode 7, I=1), at T3, SC<=0:
  - SKI: PC_inc if FGI.
  - SKO: PC_inc if FGO.
  - ION: IEN_set.
  - IOF: IEN_reset.
  - OUT: BUS_sel=4, OUTR_load.
  - INP: no-op.
- SC advances by 1 otherwise. SC is never 7.
- Halted: SC frozen, all controls 0, until reset.
- Interrupt detect: when SC not in {0,1,2}, IEN_out=1, (FGI|FGO)=1 and R_out=0, assert R_load. This is concurrent with the normal step.
- Interrupt cycle (R_out=1, overrides fetch):
  - T0: AR_reset; BUS_sel=2, TR_load.
  - T1: BUS_sel=6, M_write, PC_reset.
  - T2: PC_inc, IEN_reset, R_reset, SC<=0.
- Reset mid-instruction aborts it immediately.

Optional Feature:
- Macro: BASIC_CTRL_INTERRUPT_EN.
- Defined: interrupt detect and interrupt cycle as above.
- Undefined: R_load never asserted; R_out ignored; FGI/FGO are used only by SKI/SKO.

Test Plan:
- Reset then run: the first step is T0 with AR_load=1, BUS_sel=2. At T1: M_read=1, IR_load=1, PC_inc=1. At T2: AR_load=1, BUS_sel=5.
- IR=16'h1050 (ADD, direct): T3 idle. T4 DR_load=1, BUS_sel=7. T5 AC_load=1, ALU_ops=1. SC returns to 0 after 6 cycles.
- IR=16'hE050 (ISZ, indirect), DR_ZERO=1 at T6: T3 AR_load from M, then T4 DR_load, T5 DR_inc, T6 M_write=1, BUS_sel=3, PC_inc=1. With DR_ZERO=0 at T6: PC_inc=0.
- IR=16'h7001 (HLT): halted=1 after T3. SC stays 0 for 20 cycles with all controls 0. reset_n=0 clears halted.
- IEN_out=1, FGI=1 during T3 of 16'h7800 (CLA): R_load=1 and AC_reset=1 in the same cycle. Next cycles: T0 AR_reset and TR_load (BUS_sel=2); T1 M_write (BUS_sel=6) and PC_reset; T2 PC_inc, IEN_reset, R_reset.
- reset_n=0 during T5 of BSA: next cycle SC=0 and PC_load=0.
